// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// mips_pkg : shared MIPS-32 opcodes, control select encodings and FSM states
// Revision : 1.0
// ============================================================================
package mips_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] R_TYPE     = 6'b000000;
  localparam logic [5:0] LOAD_WORD  = 6'b100011;
  localparam logic [5:0] STORE_WORD = 6'b101011;
  localparam logic [5:0] BRANCH_EQ  = 6'b000100;
  localparam logic [5:0] JUMP       = 6'b000010;

  // R-type funct codes used by the ALU control decode
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2a;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_REG     = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_TRAP      = 4'd10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/multi_cycle_control.sv
`default_nettype none
// ============================================================================
// multi_cycle_control : multi-cycle MIPS-32 control sequencer with retire count
// Revision : 1.0
// ============================================================================
module multi_cycle_control
  import mips_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           pc_source,
  output logic [3:0]           state,
  output logic                 trap,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q;
  state_t               state_d;
  logic                 rdy;
  logic                 retire;
  logic                 trap_q;
  logic [CNT_WIDTH-1:0] count_q;

  assign rdy         = mem_ready | ~MEM_WAIT_EN;
  assign state       = state_q;
  assign trap        = trap_q;
  assign instr_count = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      count_q <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) count_q <= count_q + CNT_ONE;
      trap_q  <= trap_q | (state_d == S_TRAP);
    end
  end

  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUB_REG;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUB_FOUR;
        ir_write  = rdy;
        pc_write  = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = ALUB_IMM_SH2;
        case (opcode)
          LOAD_WORD, STORE_WORD: state_d = S_MEM_ADDR;
          R_TYPE:                state_d = S_EXECUTE;
          BRANCH_EQ:             state_d = S_BRANCH;
          JUMP:                  state_d = S_JUMP;
          default:               state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        if (opcode == LOAD_WORD)       state_d = S_MEM_READ;
        else if (opcode == STORE_WORD) state_d = S_MEM_WRITE;
        else                           state_d = S_TRAP;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (rdy) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (rdy) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    // Reset overrides every architectural side effect, even mid-instruction
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      retire        = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_control.sv
`default_nettype none
// ============================================================================
// tb_multi_cycle_control : randomized self-checking bench for multi_cycle_control
// Revision : 1.0
// ============================================================================
module tb_multi_cycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: 32-bit counter, waits on mem_ready
  logic        rst, mem_ready;
  logic [5:0]  opcode;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, trap;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [31:0] instr_count;

  // Small instance: 4-bit counter, mem_ready ignored
  logic        rst4, mem_ready4;
  logic [5:0]  opcode4;
  logic        pc_write4, pc_write_cond4, i_or_d4, mem_read4, mem_write4, ir_write4;
  logic        mem_to_reg4, reg_dst4, reg_write4, alu_src_a4, trap4;
  logic [1:0]  alu_src_b4, alu_op4, pc_source4;
  logic [3:0]  state4;
  logic [3:0]  instr_count4;

  multi_cycle_control #(.CNT_WIDTH(32), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .trap(trap), .instr_count(instr_count)
  );

  multi_cycle_control #(.CNT_WIDTH(4), .MEM_WAIT_EN(1'b0)) dut4 (
    .clk(clk), .rst(rst4), .opcode(opcode4), .mem_ready(mem_ready4),
    .pc_write(pc_write4), .pc_write_cond(pc_write_cond4), .i_or_d(i_or_d4),
    .mem_read(mem_read4), .mem_write(mem_write4), .ir_write(ir_write4),
    .mem_to_reg(mem_to_reg4), .reg_dst(reg_dst4), .reg_write(reg_write4),
    .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .alu_op(alu_op4),
    .pc_source(pc_source4), .state(state4), .trap(trap4), .instr_count(instr_count4)
  );

  wire [15:0] ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
  wire [15:0] ctrl4 = {pc_write4, pc_write_cond4, i_or_d4, mem_read4, mem_write4, ir_write4,
                       mem_to_reg4, reg_dst4, reg_write4, alu_src_a4, alu_src_b4, alu_op4, pc_source4};

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int unsigned model_cnt = 0;

  // Control word expected in each state, straight from the state table
  function automatic logic [15:0] ref_ctrl(input int st, input bit r);
    bit pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, irw = 0, mtr = 0, rd = 0, rw = 0, asa = 0;
    bit [1:0] asb = 2'b00, aop = 2'b00, pcs = 2'b00;
    case (st)
      0:  begin mr = 1; asb = 2'b01; irw = r; pw = r; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; mtr = 1; end
      5:  begin mw = 1; iod = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
      9:  begin pw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, mtr, rd, rw, asa, asb, aop, pcs};
  endfunction

  // Runs one instruction on the main instance; entered and left at posedge+1
  task automatic exec_instr(input logic [5:0] op, input int fw, input int mw);
    int sq[$];
    bit rq[$];
    repeat (fw) begin sq.push_back(0); rq.push_back(1'b0); end
    sq.push_back(0); rq.push_back(1'b1);
    sq.push_back(1); rq.push_back(1'b1);
    case (op)
      6'b000000: begin sq.push_back(6); rq.push_back(1'b1); sq.push_back(7); rq.push_back(1'b1); end
      6'b100011: begin
        sq.push_back(2); rq.push_back(1'b1);
        repeat (mw) begin sq.push_back(3); rq.push_back(1'b0); end
        sq.push_back(3); rq.push_back(1'b1);
        sq.push_back(4); rq.push_back(1'b1);
      end
      6'b101011: begin
        sq.push_back(2); rq.push_back(1'b1);
        repeat (mw) begin sq.push_back(5); rq.push_back(1'b0); end
        sq.push_back(5); rq.push_back(1'b1);
      end
      6'b000100: begin sq.push_back(8); rq.push_back(1'b1); end
      default:   begin sq.push_back(9); rq.push_back(1'b1); end
    endcase
    foreach (sq[i]) begin
      mem_ready = (sq[i] == 0 || sq[i] == 3 || sq[i] == 5) ? rq[i] : 1'($urandom);
      opcode    = (sq[i] == 0) ? 6'($urandom) : op;
      #1;
      total_cnt++;
      if (state !== 4'(sq[i]))
        $display("FAIL state op=%b cyc=%0d: got %0d expected %0d", op, i, state, sq[i]);
      else pass_cnt++;
      total_cnt++;
      if (ctrl !== ref_ctrl(sq[i], rq[i]))
        $display("FAIL ctrl op=%b st=%0d: got %h expected %h", op, sq[i], ctrl, ref_ctrl(sq[i], rq[i]));
      else pass_cnt++;
      @(posedge clk); #1;
    end
    model_cnt++;
    total_cnt++;
    if (instr_count !== model_cnt)
      $display("FAIL count op=%b: got %0d expected %0d", op, instr_count, model_cnt);
    else pass_cnt++;
    total_cnt++;
    if (state !== 4'd0) $display("FAIL end_state op=%b: got %0d expected 0", op, state);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst4 = 1'b1; mem_ready = 1'b1; mem_ready4 = 1'b0;
    opcode = 6'b000000; opcode4 = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (state !== 4'd0 || trap !== 1'b0 || instr_count !== 32'd0)
      $display("FAIL reset_regs: got st=%0d trap=%b cnt=%0d expected 0/0/0", state, trap, instr_count);
    else pass_cnt++;
    total_cnt++;
    if (pc_write !== 1'b0 || ir_write !== 1'b0 || mem_read !== 1'b0)
      $display("FAIL reset_gating: got pw=%b irw=%b mr=%b expected 0", pc_write, ir_write, mem_read);
    else pass_cnt++;
    total_cnt++;
    if (state4 !== 4'd0 || instr_count4 !== 4'd0)
      $display("FAIL reset_dut4: got st=%0d cnt=%0d expected 0/0", state4, instr_count4);
    else pass_cnt++;
    rst = 1'b0;
    model_cnt = 0;
  endtask

  task automatic test_rtype();        exec_instr(6'b000000, 0, 0); endtask
  task automatic test_lw_wait();      exec_instr(6'b100011, 0, 3); endtask
  task automatic test_sw_fetch_wait(); exec_instr(6'b101011, 2, 0); endtask

  task automatic test_back_to_back();
    exec_instr(6'b000100, 0, 0);
    exec_instr(6'b000010, 0, 0);
  endtask

  task automatic test_random();
    logic [5:0] ops [5] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
    for (int n = 0; n < 30; n++)
      exec_instr(ops[$urandom_range(4)], $urandom_range(3), $urandom_range(3));
  endtask

  task automatic test_reset_mid();
    exec_instr(6'b000000, 0, 0);
    mem_ready = 1'b1; opcode = 6'b000000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (state !== 4'd7 || reg_write !== 1'b0)
      $display("FAIL reset_mid_rwb: got st=%0d rw=%b expected 7/0", state, reg_write);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    model_cnt = 0;
    total_cnt++;
    if (state !== 4'd0 || instr_count !== 32'd0)
      $display("FAIL reset_mid_after: got st=%0d cnt=%0d expected 0/0", state, instr_count);
    else pass_cnt++;
  endtask

  task automatic test_trap();
    mem_ready = 1'b1; opcode = 6'($urandom);
    @(posedge clk); #1;
    opcode = 6'b001000;
    #1;
    total_cnt++;
    if (state !== 4'd1 || trap !== 1'b0)
      $display("FAIL trap_decode: got st=%0d trap=%b expected 1/0", state, trap);
    else pass_cnt++;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom);
      #1;
      total_cnt++;
      if (state !== 4'd10 || trap !== 1'b1 || ctrl !== 16'h0000 || instr_count !== model_cnt)
        $display("FAIL trap_hold cyc=%0d: got st=%0d trap=%b ctrl=%h cnt=%0d expected 10/1/0000/%0d",
                 i, state, trap, ctrl, instr_count, model_cnt);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_cnt = 0;
    total_cnt++;
    if (state !== 4'd0 || trap !== 1'b0 || instr_count !== 32'd0)
      $display("FAIL trap_clear: got st=%0d trap=%b cnt=%0d expected 0/0/0", state, trap, instr_count);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int seq [4] = '{0, 1, 6, 7};
    rst4 = 1'b0; mem_ready4 = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      for (int k = 0; k < 4; k++) begin
        opcode4 = (k == 0) ? 6'($urandom) : 6'b000000;
        #1;
        total_cnt++;
        if (state4 !== 4'(seq[k]) || ctrl4 !== ref_ctrl(seq[k], 1'b1))
          $display("FAIL wrap_seq n=%0d: got st=%0d ctrl=%h expected %0d/%h",
                   n, state4, ctrl4, seq[k], ref_ctrl(seq[k], 1'b1));
        else pass_cnt++;
        @(posedge clk); #1;
      end
      total_cnt++;
      if (instr_count4 !== 4'(n % 16))
        $display("FAIL wrap_count n=%0d: got %0d expected %0d", n, instr_count4, n % 16);
      else pass_cnt++;
    end
    // Abandon an R-type in EXECUTE: nothing may retire or write back
    opcode4 = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    rst4 = 1'b1;
    #1;
    total_cnt++;
    if (state4 !== 4'd6 || reg_write4 !== 1'b0)
      $display("FAIL wrap_rst_exec: got st=%0d rw=%b expected 6/0", state4, reg_write4);
    else pass_cnt++;
    @(posedge clk); #1;
    rst4 = 1'b0;
    #1;
    total_cnt++;
    if (state4 !== 4'd0 || instr_count4 !== 4'd0 || reg_write4 !== 1'b0)
      $display("FAIL wrap_rst_after: got st=%0d cnt=%0d rw=%b expected 0/0/0",
               state4, instr_count4, reg_write4);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_fetch_wait();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_trap();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
